// File: rtl/gobou_ctrl_pkg.sv
// Shared constants, state encoding and config record for the gobou_core sequencer.
package gobou_ctrl_pkg;

    localparam int DWIDTH   = 16;
    localparam int LWIDTH   = 10;
    localparam int IMGSIZE  = 12;
    localparam int WGTSIZE  = 16;
    localparam int TAIL_LEN = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MAC,
        S_BIAS,
        S_TAIL,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [LWIDTH-1:0]  total_in;
        logic [LWIDTH-1:0]  total_out;
        logic [IMGSIZE-1:0] in_offset;
        logic [WGTSIZE-1:0] w_offset;
        logic [IMGSIZE-1:0] out_offset;
    } cfg_t;

    // A layer with no inputs or no neurons does no memory traffic at all.
    function automatic logic is_empty_layer(input logic [LWIDTH-1:0] n_in,
                                            input logic [LWIDTH-1:0] n_out);
        return (n_in == '0) || (n_out == '0);
    endfunction

endpackage

// File: rtl/gobou_ctrl_if.sv
// Host handshake, layer config, memory addresses and datapath enables of gobou_ctrl.
interface gobou_ctrl_if;
    import gobou_ctrl_pkg::*;

    logic               req;
    logic               ack;
    logic [LWIDTH-1:0]  total_in;
    logic [LWIDTH-1:0]  total_out;
    logic [IMGSIZE-1:0] in_offset;
    logic [WGTSIZE-1:0] w_offset;
    logic [IMGSIZE-1:0] out_offset;
    logic [IMGSIZE-1:0] mem_in_addr;
    logic [WGTSIZE-1:0] mem_w_addr;
    logic               mem_out_we;
    logic [IMGSIZE-1:0] mem_out_addr;
    logic               accum_rst;
    logic               accum_we;
    logic               mac_oe;
    logic               breg_we;
    logic               bias_oe;
    logic               relu_oe;

    modport master (
        output req, total_in, total_out, in_offset, w_offset, out_offset,
        input  ack, mem_in_addr, mem_w_addr, mem_out_we, mem_out_addr,
        input  accum_rst, accum_we, mac_oe, breg_we, bias_oe, relu_oe
    );

    modport slave (
        input  req, total_in, total_out, in_offset, w_offset, out_offset,
        output ack, mem_in_addr, mem_w_addr, mem_out_we, mem_out_addr,
        output accum_rst, accum_we, mac_oe, breg_we, bias_oe, relu_oe
    );

endinterface

// File: rtl/gobou_ctrl.sv
// Fully connected layer sequencer: walks neurons and inputs, drives memory
// addresses and the mac -> bias -> relu enables of one gobou_core.
module gobou_ctrl
    import gobou_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        xrst,
    gobou_ctrl_if.slave bus
);

    localparam logic [1:0] TAIL_LAST = 2'(TAIL_LEN - 1);

    state_t             state;
    cfg_t               cfg;
    logic [LWIDTH-1:0]  i;
    logic [LWIDTH-1:0]  o;
    logic [1:0]         p;
    logic [WGTSIZE-1:0] w_ptr;

    logic               ack;
    logic [IMGSIZE-1:0] mem_in_addr;
    logic [WGTSIZE-1:0] mem_w_addr;
    logic               mem_out_we;
    logic [IMGSIZE-1:0] mem_out_addr;
    logic               accum_rst;
    logic               accum_we;
    logic               mac_oe;
    logic               breg_we;
    logic               bias_oe;
    logic               relu_oe;

    logic [LWIDTH-1:0]  i_next;
    logic [LWIDTH-1:0]  o_next;
    logic               last_in;
    logic               last_out;

    assign i_next   = i + LWIDTH'(1);
    assign o_next   = o + LWIDTH'(1);
    assign last_in  = (i == cfg.total_in - LWIDTH'(1));
    assign last_out = (o == cfg.total_out - LWIDTH'(1));

    // Outputs are loaded with the values belonging to the state being entered,
    // so every address and enable comes straight from a flop.
    // The weight pointer runs linearly across all neurons, so each neuron's
    // base falls out naturally without multiplying by total_in+1.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state        <= S_IDLE;
            cfg          <= '0;
            i            <= '0;
            o            <= '0;
            p            <= '0;
            w_ptr        <= '0;
            ack          <= 1'b1;
            mem_in_addr  <= '0;
            mem_w_addr   <= '0;
            mem_out_we   <= 1'b0;
            mem_out_addr <= '0;
            accum_rst    <= 1'b0;
            accum_we     <= 1'b0;
            mac_oe       <= 1'b0;
            breg_we      <= 1'b0;
            bias_oe      <= 1'b0;
            relu_oe      <= 1'b0;
        end else begin
            accum_rst  <= 1'b0;
            mac_oe     <= 1'b0;
            breg_we    <= 1'b0;
            bias_oe    <= 1'b0;
            relu_oe    <= 1'b0;
            mem_out_we <= 1'b0;
            // Read data arrives one cycle after its address, hence the delay.
            accum_we   <= (state == S_MAC);

            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        cfg.total_in   <= bus.total_in;
                        cfg.total_out  <= bus.total_out;
                        cfg.in_offset  <= bus.in_offset;
                        cfg.w_offset   <= bus.w_offset;
                        cfg.out_offset <= bus.out_offset;
                        ack            <= 1'b0;
                        if (is_empty_layer(bus.total_in, bus.total_out)) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_CLR;
                            o         <= '0;
                            w_ptr     <= bus.w_offset;
                            accum_rst <= 1'b1;
                        end
                    end
                end

                S_CLR: begin
                    state       <= S_MAC;
                    i           <= '0;
                    mem_in_addr <= cfg.in_offset;
                    mem_w_addr  <= w_ptr;
                    w_ptr       <= w_ptr + WGTSIZE'(1);
                end

                S_MAC: begin
                    mem_w_addr <= w_ptr;
                    w_ptr      <= w_ptr + WGTSIZE'(1);
                    if (last_in) begin
                        state <= S_BIAS;
                    end else begin
                        i           <= i_next;
                        mem_in_addr <= cfg.in_offset + IMGSIZE'(i_next);
                    end
                end

                S_BIAS: begin
                    state   <= S_TAIL;
                    p       <= '0;
                    breg_we <= 1'b1;
                    mac_oe  <= 1'b1;
                end

                S_TAIL: begin
                    p <= p + 2'd1;
                    case (p)
                        2'd0: bias_oe <= 1'b1;
                        2'd1: relu_oe <= 1'b1;
                        2'd2: begin
                            mem_out_we   <= 1'b1;
                            mem_out_addr <= cfg.out_offset + IMGSIZE'(o);
                        end
                        default: ;
                    endcase
                    if (p == TAIL_LAST) begin
                        if (last_out) begin
                            state <= S_DONE;
                        end else begin
                            state     <= S_CLR;
                            o         <= o_next;
                            accum_rst <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    ack   <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                    ack   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ack          = ack;
    assign bus.mem_in_addr  = mem_in_addr;
    assign bus.mem_w_addr   = mem_w_addr;
    assign bus.mem_out_we   = mem_out_we;
    assign bus.mem_out_addr = mem_out_addr;
    assign bus.accum_rst    = accum_rst;
    assign bus.accum_we     = accum_we;
    assign bus.mac_oe       = mac_oe;
    assign bus.breg_we      = breg_we;
    assign bus.bias_oe      = bias_oe;
    assign bus.relu_oe      = relu_oe;

endmodule

// File: tb/tb_gobou_ctrl.sv
// Scoreboard bench for gobou_ctrl with a behavioural gobou_core and memories.
module tb_gobou_ctrl;
    import gobou_ctrl_pkg::*;

    logic clk;
    logic xrst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gobou_ctrl_if bus ();

    gobou_ctrl dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    typedef struct packed {
        logic               ack;
        logic               accum_rst;
        logic               accum_we;
        logic               mac_oe;
        logic               breg_we;
        logic               bias_oe;
        logic               relu_oe;
        logic               out_we;
        logic               in_v;
        logic [IMGSIZE-1:0] in_addr;
        logic               w_v;
        logic [WGTSIZE-1:0] w_addr;
        logic [IMGSIZE-1:0] out_addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Behavioural datapath: 1-cycle read memories feeding mac -> bias -> relu.
    logic signed [DWIDTH-1:0]   in_mem [0:(1<<IMGSIZE)-1];
    logic signed [DWIDTH-1:0]   w_mem  [0:(1<<WGTSIZE)-1];
    logic signed [DWIDTH-1:0]   in_q, w_q, breg, relu_q;
    logic signed [2*DWIDTH-1:0] acc, mac_q, sum_q;
    int                         wr_count = 0;
    logic [DWIDTH-1:0]          wr_data;
    logic [IMGSIZE-1:0]         wr_addr;

    always_ff @(posedge clk) begin
        in_q <= in_mem[bus.mem_in_addr];
        w_q  <= w_mem[bus.mem_w_addr];
        if (bus.accum_rst) acc <= '0;
        else if (bus.accum_we) acc <= acc + (in_q * w_q);
        if (bus.mac_oe)  mac_q  <= acc;
        if (bus.breg_we) breg   <= w_q;
        if (bus.bias_oe) sum_q  <= mac_q + breg;
        if (bus.relu_oe) relu_q <= sum_q[2*DWIDTH-1] ? '0 : sum_q[DWIDTH-1:0];
    end

    always @(posedge clk) begin
        if (bus.mem_out_we === 1'b1) begin
            wr_count = wr_count + 1;
            wr_data  = relu_q;
            wr_addr  = bus.mem_out_addr;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected per-cycle outputs from the accepting edge until ack returns.
    task automatic push_run(input int ti, input int to, input logic [IMGSIZE-1:0] ino,
                            input logic [WGTSIZE-1:0] wo, input logic [IMGSIZE-1:0] oo);
        exp_t               e;
        logic [WGTSIZE-1:0] wp;
        wp = wo;
        if (ti != 0 && to != 0) begin
            for (int n = 0; n < to; n++) begin
                e = '0; e.accum_rst = 1'b1; exp_q.push_back(e);
                for (int k = 0; k < ti; k++) begin
                    e = '0;
                    e.in_v = 1'b1; e.in_addr = ino + IMGSIZE'(k);
                    e.w_v  = 1'b1; e.w_addr  = wp;
                    e.accum_we = (k > 0);
                    wp = wp + WGTSIZE'(1);
                    exp_q.push_back(e);
                end
                e = '0; e.w_v = 1'b1; e.w_addr = wp; e.accum_we = 1'b1; exp_q.push_back(e);
                wp = wp + WGTSIZE'(1);
                e = '0; e.breg_we = 1'b1; e.mac_oe = 1'b1; exp_q.push_back(e);
                e = '0; e.bias_oe = 1'b1; exp_q.push_back(e);
                e = '0; e.relu_oe = 1'b1; exp_q.push_back(e);
                e = '0; e.out_we = 1'b1; e.out_addr = oo + IMGSIZE'(n); exp_q.push_back(e);
            end
        end
        e = '0; exp_q.push_back(e);
        e = '0; e.ack = 1'b1; exp_q.push_back(e);
    endtask

    task automatic scramble_cfg();
        bus.total_in   = LWIDTH'($urandom_range(0, 1023));
        bus.total_out  = LWIDTH'($urandom_range(0, 1023));
        bus.in_offset  = IMGSIZE'($urandom_range(0, 4095));
        bus.w_offset   = WGTSIZE'($urandom_range(0, 65535));
        bus.out_offset = IMGSIZE'($urandom_range(0, 4095));
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL %s drain: %0d expected cycles left, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic apply_stimulus(input string name, input int ti, input int to,
                                  input logic [IMGSIZE-1:0] ino, input logic [WGTSIZE-1:0] wo,
                                  input logic [IMGSIZE-1:0] oo, input int exp_busy,
                                  input bit hold_req, input bit scramble);
        int n;
        @(posedge clk); #1;
        bus.total_in   = LWIDTH'(ti);
        bus.total_out  = LWIDTH'(to);
        bus.in_offset  = ino;
        bus.w_offset   = wo;
        bus.out_offset = oo;
        bus.req        = 1'b1;
        @(posedge clk);
        push_run(ti, to, ino, wo, oo);
        #1;
        if (!hold_req) bus.req = 1'b0;
        if (scramble) scramble_cfg();
        n = 0;
        while (bus.ack !== 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
            if (scramble) scramble_cfg();
        end
        bus.req = 1'b0;
        check_output({name, " busy"}, n, exp_busy);
        wait_drain(name);
    endtask

    // Monitor: every cycle either matches the next expected entry or must be quiet idle.
    initial begin
        exp_t        e;
        logic [7:0]  act_ctl;
        logic [7:0]  exp_ctl;
        bit          ok;
        forever begin
            @(negedge clk);
            act_ctl = {bus.ack, bus.accum_rst, bus.accum_we, bus.mac_oe,
                       bus.breg_we, bus.bias_oe, bus.relu_oe, bus.mem_out_we};
            checks++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_ctl = {e.ack, e.accum_rst, e.accum_we, e.mac_oe,
                           e.breg_we, e.bias_oe, e.relu_oe, e.out_we};
                ok = (act_ctl === exp_ctl);
                if (e.in_v   && bus.mem_in_addr  !== e.in_addr)  ok = 1'b0;
                if (e.w_v    && bus.mem_w_addr   !== e.w_addr)   ok = 1'b0;
                if (e.out_we && bus.mem_out_addr !== e.out_addr) ok = 1'b0;
                if (!ok) begin
                    fails++;
                    $display("[TB] FAIL cycle @%0t: got ctl=%b in=0x%0h w=0x%0h out=0x%0h, expected ctl=%b in=0x%0h(%0b) w=0x%0h(%0b) out=0x%0h",
                             $time, act_ctl, bus.mem_in_addr, bus.mem_w_addr, bus.mem_out_addr,
                             exp_ctl, e.in_addr, e.in_v, e.w_addr, e.w_v, e.out_addr);
                end
            end else if (act_ctl !== 8'b1000_0000) begin
                fails++;
                $display("[TB] FAIL idle @%0t: got ctl=%b, expected ctl=10000000", $time, act_ctl);
            end
        end
    end

    initial begin
        int wc;
        xrst           = 1'b1;
        bus.req        = 1'b0;
        bus.total_in   = '0;
        bus.total_out  = '0;
        bus.in_offset  = '0;
        bus.w_offset   = '0;
        bus.out_offset = '0;
        for (int k = 0; k < (1 << IMGSIZE); k++) in_mem[k] = '0;
        for (int k = 0; k < (1 << WGTSIZE); k++) w_mem[k]  = '0;
        in_mem[12'h010] = 16'sd1;
        in_mem[12'h011] = 16'sd2;
        in_mem[12'h012] = 16'sd3;
        w_mem[16'h0100] = 16'sd1;
        w_mem[16'h0101] = 16'hFFFF;
        w_mem[16'h0102] = 16'sd2;
        w_mem[16'h0103] = 16'hFFF6;

        #2 xrst = 1'b0;
        #20;
        check_output("reset ack",      32'(bus.ack), 1);
        check_output("reset in_addr",  32'(bus.mem_in_addr), 0);
        check_output("reset w_addr",   32'(bus.mem_w_addr), 0);
        check_output("reset out_addr", 32'(bus.mem_out_addr), 0);
        @(posedge clk); #3 xrst = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] single neuron, bias -10");
        wc = wr_count;
        apply_stimulus("single", 3, 1, 12'h010, 16'h0100, 12'h020, 10, 1'b0, 1'b0);
        check_output("single writes", wr_count - wc, 1);
        check_output("single wr_addr", 32'(wr_addr), 32'h020);
        check_output("golden relu neg", 32'(wr_data), 0);

        $display("[TB] single neuron, bias +10");
        w_mem[16'h0103] = 16'sd10;
        apply_stimulus("golden", 3, 1, 12'h010, 16'h0100, 12'h020, 10, 1'b0, 1'b0);
        check_output("golden relu pos", 32'(wr_data), 15);

        $display("[TB] two neurons");
        wc = wr_count;
        apply_stimulus("two", 2, 2, 12'h040, 16'h0000, 12'h080, 17, 1'b0, 1'b0);
        check_output("two writes", wr_count - wc, 2);
        check_output("two last wr_addr", 32'(wr_addr), 32'h081);

        $display("[TB] degenerate layers");
        wc = wr_count;
        apply_stimulus("empty in", 0, 5, 12'h010, 16'h0100, 12'h020, 1, 1'b0, 1'b0);
        apply_stimulus("empty out", 4, 0, 12'h010, 16'h0100, 12'h020, 1, 1'b0, 1'b0);
        check_output("empty writes", wr_count - wc, 0);

        $display("[TB] address wrap");
        apply_stimulus("wrap", 2, 1, 12'hFFF, 16'hFFFE, 12'hFFF, 9, 1'b0, 1'b0);

        $display("[TB] req held and config changed while busy");
        apply_stimulus("robust", 3, 2, 12'h010, 16'h0200, 12'h050, 19, 1'b1, 1'b1);
        repeat (5) @(posedge clk);

        $display("[TB] reset during MAC");
        @(posedge clk); #1;
        bus.total_in   = 10'd8;
        bus.total_out  = 10'd1;
        bus.in_offset  = 12'h100;
        bus.w_offset   = 16'h0400;
        bus.out_offset = 12'h060;
        bus.req        = 1'b1;
        @(posedge clk);
        push_run(8, 1, 12'h100, 16'h0400, 12'h060);
        #1 bus.req = 1'b0;
        repeat (3) @(posedge clk);
        #3 xrst = 1'b0;
        exp_q.delete();
        wc = wr_count;
        #1;
        check_output("abort ack", 32'(bus.ack), 1);
        check_output("abort enables", 32'({bus.accum_rst, bus.accum_we, bus.mac_oe, bus.breg_we,
                                            bus.bias_oe, bus.relu_oe, bus.mem_out_we}), 0);
        check_output("abort in_addr", 32'(bus.mem_in_addr), 0);
        check_output("abort w_addr", 32'(bus.mem_w_addr), 0);
        @(posedge clk); #3 xrst = 1'b1;
        repeat (20) @(posedge clk);
        check_output("abort no write", wr_count - wc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/gobou_ctrl.md
Name: gobou_ctrl

Overview:
- Sequencer for one gobou_core datapath (mac -> bias -> relu) running a fully connected layer.
- Triggered by a req/ack handshake from the host-side ninjin interface.
- Generates input, weight and output memory addresses and every datapath enable.
- Processes total_out neurons of total_in inputs each. Weights are stored per neuron as total_in weights followed by one bias word.

Parameters:
- LWIDTH, 10: width of total_in/total_out counters.
- IMGSIZE, 12: input/output buffer address width.
- WGTSIZE, 16: weight memory address width.

Ports:
- clk  in  1  clock
- xrst  in  1  asynchronous active-low reset
- req  in  1  start pulse; sampled only in S_IDLE
- total_in  in  LWIDTH  inputs per neuron
- total_out  in  LWIDTH  neurons in layer
- in_offset  in  IMGSIZE  input buffer base address
- w_offset  in  WGTSIZE  weight memory base address
- out_offset  in  IMGSIZE  output buffer base address
- ack  out  1  high when idle and ready
- mem_in_addr  out  IMGSIZE  input buffer read address (1-cycle read latency)
- mem_w_addr  out  WGTSIZE  weight memory read address (1-cycle read latency)
- mem_out_we  out  1  output buffer write strobe
- mem_out_addr  out  IMGSIZE  output buffer write address
- accum_rst, accum_we, mac_oe, breg_we, bias_oe, relu_oe  out  1 each  gobou_core controls

Behaviour:
- Reset (xrst=0, asynchronous):
  - State S_IDLE; ack=1.
  - All addresses 0; all strobes and enables 0.
  - Reset mid-layer aborts immediately. No write is completed after reset.
- All outputs are registered.
- Config latching: config is latched on the cycle req=1 in S_IDLE. Later changes to config inputs are ignored until the next start. A req outside S_IDLE is ignored.
- States:
  - S_IDLE: ack=1. On req: if total_in==0 or total_out==0, go to S_DONE; else go to S_CLR with o=0 and w_ptr=w_offset.
  - S_CLR (1 cycle): accum_rst=1, i=0.
  - S_MAC (total_in cycles):
    - mem_in_addr = in_offset+i; mem_w_addr = w_ptr.
    - w_ptr increments, then i increments.
    - accum_we is asserted one cycle after each address (data-valid alignment), so accum_we is a 1-cycle-delayed copy of "in S_MAC".
    - When i==total_in-1, go to S_BIAS.
  - S_BIAS (1 cycle): mem_w_addr = w_ptr (the bias word); w_ptr increments. The final accum_we pulse occurs in this cycle.
  - S_TAIL (4 cycles, phase p=0..3):
    - p0: breg_we=1, mac_oe=1.
    - p1: bias_oe=1.
    - p2: relu_oe=1.
    - p3: mem_out_we=1, mem_out_addr = out_offset+o.
    - After p3: if o==total_out-1, go to S_DONE; else o++ and go to S_CLR.
  - S_DONE (1 cycle): ack=0, then go to S_IDLE.
- ack is 0 in every state except S_IDLE, so ack drops on the cycle after req is accepted.
- Weight pointer:
  - w_ptr walks linearly; neuron o's base is w_offset + o*(total_in+1). No multiplier.
  - All address arithmetic wraps modulo 2^width.
- Timing:
  - Cycles per neuron = total_in+6.
  - Busy time from req to ack high = total_out*(total_in+6)+1 cycles.
  - Degenerate cases (total_in==0 or total_out==0): busy time = 1 cycle, with no memory access and no enables.
- Every enable is a single-cycle pulse. At most one of breg_we/bias_oe/relu_oe/mem_out_we is high per cycle. accum_rst and accum_we are never high together.

Decomposition:
- gobou.vh / ninjin.vh hold:
  - DWIDTH, LWIDTH, IMGSIZE, WGTSIZE.
  - State encodings S_IDLE, S_CLR, S_MAC, S_BIAS, S_TAIL, S_DONE.
  - TAIL_LEN=4.
- No sub-module. The FSM, counters and the 1-stage accum_we delay live in one file.

Test Plan:
- Reset then idle: xrst low mid-S_MAC -> state S_IDLE, ack=1, all enables 0 on that cycle; no mem_out_we afterwards.
- Single neuron: total_in=3, total_out=1, in_offset=0x10, w_offset=0x100, out_offset=0x20 ->
  - mem_in_addr 0x10,0x11,0x12.
  - mem_w_addr 0x100..0x103.
  - accum_we on 3 consecutive cycles starting one after the first address.
  - mem_out_we once at 0x20.
  - ack high again 10 cycles after req.
- Two neurons: total_in=2, total_out=2, w_offset=0 -> weight addresses 0,1,2 then 3,4,5; writes at out_offset and out_offset+1; busy time 17 cycles.
- Golden datapath: connect gobou_core plus memory models, inputs {1,2,3}, weights {1,-1,2}, bias -10 -> result relu(1-2+6-10)=0. Bias +10 -> 15 written.
- Degenerate: total_in=0, total_out=5 -> no enables, ack low exactly 1 cycle.
- Robustness:
  - req held high while busy -> no restart.
  - Config inputs changed mid-run -> addresses unaffected.
  - w_offset=0xFFFE -> address wraps to 0x0000.
